// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush, stall and a saturating back-pressure counter.
// Define PIPE_STAGE_REG_SKID_EN to add a skid entry that removes the combinational out_ready -> in_ready path.
module pipe_stage_reg #(
    parameter int                 WIDTH   = 32,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    parameter int                 CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stall,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   bp_cnt
);

    logic             main_vld_q, main_vld_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [CNT_W-1:0] bp_q, bp_d;
    logic             push, pop;

    assign pop       = main_vld_q & out_ready & ~stall;
    assign push      = in_valid & in_ready;
    assign out_valid = main_vld_q;
    assign out_data  = main_data_q;
    assign bp_cnt    = bp_q;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // Ready depends only on held state, so downstream timing never reaches upstream.
    assign in_ready  = ~skid_vld_q & ~stall & ~rst;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (pop) begin
                main_data_d = skid_data_q;
                skid_vld_d  = 1'b0;
            end
        end else if (main_vld_q) begin
            if (pop && push) begin
                main_data_d = in_data;
            end else if (pop) begin
                main_vld_d = 1'b0;
            end else if (push) begin
                skid_data_d = in_data;
                skid_vld_d  = 1'b1;
            end
        end else if (push) begin
            main_data_d = in_data;
            main_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_vld_q <= 1'b0;
        end else begin
            skid_vld_q <= skid_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end
`else
    assign in_ready  = (~main_vld_q | out_ready) & ~stall & ~rst;
    assign occupancy = {1'b0, main_vld_q};

    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        if (flush) begin
            main_vld_d = 1'b0;
        end else if (push) begin
            main_data_d = in_data;
            main_vld_d  = 1'b1;
        end else if (pop) begin
            main_vld_d = 1'b0;
        end
    end
`endif

    always_comb begin
        bp_d = bp_q;
        if (main_vld_q && (!out_ready || stall) && !(&bp_q)) begin
            bp_d = bp_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q  <= 1'b0;
            main_data_q <= RST_VAL;
            bp_q        <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            bp_q        <= bp_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios then randomized traffic against a queue model.
module tb_pipe_stage_reg;

    localparam int          WIDTH = 32;
    localparam int          CNT_W = 4;
    localparam logic [31:0] RSTV  = 32'h1C000000;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam int          CAP   = 2;
`else
    localparam int          CAP   = 1;
`endif

    logic             clk = 1'b0;
    logic             rst, flush, stall, in_valid, out_ready;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] in_data, out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] bp_cnt;

    pipe_stage_reg #(.WIDTH(WIDTH), .RST_VAL(RSTV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .bp_cnt(bp_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          run = 1'b0;
    bit          rst_known = 1'b1;
    logic [31:0] exp_q[$];
    int          exp_bp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor/scoreboard: compare visible state, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (run) begin
            bit exp_rdy;
            bit pop_ok, push_ok;
            int n;
            n = exp_q.size();
            if (rst || stall) exp_rdy = 1'b0;
            else if (CAP == 2) exp_rdy = (n < 2);
            else exp_rdy = (n == 0) || out_ready;
            chk("out_valid", 64'(out_valid), 64'(n > 0));
            chk("occupancy", 64'(occupancy), 64'(n));
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("bp_cnt", 64'(bp_cnt), 64'(exp_bp));
            if (n > 0) chk("out_data", 64'(out_data), 64'(exp_q[0]));
            else if (rst_known) chk("out_data_rst", 64'(out_data), 64'(RSTV));

            if (rst) begin
                exp_q.delete();
                exp_bp    = 0;
                rst_known = 1'b1;
            end else begin
                if (n > 0 && (!out_ready || stall) && exp_bp < (1 << CNT_W) - 1) exp_bp++;
                if (flush) begin
                    exp_q.delete();
                end else begin
                    pop_ok  = (n > 0) && out_ready && !stall;
                    push_ok = in_valid && exp_rdy;
                    if (pop_ok) void'(exp_q.pop_front());
                    if (push_ok) begin
                        exp_q.push_back(in_data);
                        rst_known = 1'b0;
                    end
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [31:0] d, input bit ordy,
                       input bit stl, input bit fl, input bit r);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        run = 1'b1;
        cyc(0, 0, 0, 0, 0, 1);
        // Reset values visible after the reset edge
        chk("reset_out_data", 64'(out_data), 64'(RSTV));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_bp", 64'(bp_cnt), 64'(0));

        // Streaming
        for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("stream_bp", 64'(bp_cnt), 64'(0));

        // Back-pressure with A, B, C
        cyc(1, 32'hA, 1, 0, 0, 0);
        cyc(1, 32'hB, 0, 0, 0, 0);
        cyc(1, 32'hC, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'hC, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        // Stall holds X
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 32'h5A5A_0001, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0);
        chk("stall_bp", 64'(bp_cnt), 64'(3));
        chk("stall_data", 64'(out_data), 64'(32'h5A5A_0001));
        cyc(0, 0, 1, 0, 0, 0);

        // Flush drops held entries and the same-cycle push
        cyc(1, 32'h11, 0, 0, 0, 0);
        cyc(1, 32'h22, 0, 0, 0, 0);
        cyc(1, 32'hDD, 0, 0, 1, 0);
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_occ", 64'(occupancy), 64'(0));

        // Saturation
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 32'h77, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("sat_bp", 64'(bp_cnt), 64'(15));
        cyc(0, 0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 99) == 0);
        end
        cyc(0, 0, 1, 0, 0, 0);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, width-parametrised pipeline stage register for the in-order CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces fixed-field stall-only stage registers with a valid/ready handshake, a flush that kills in-flight contents, an external freeze for cache stalls, and an optional skid entry. The skid entry breaks the combinational ready path between stages. A saturating back-pressure counter supports performance analysis.

## Interface
- WIDTH, 32, payload bits (concatenated stage fields: PC, inst, control, results, etc.)
- RST_VAL, {WIDTH{1'b0}}, value loaded into out_data on reset (e.g. PC field = PC_RST)
- CNT_W, 16, width of the back-pressure counter
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  invalidate all held entries (branch mispredict/exception)
- stall  in  1  external freeze (DCache/ICache miss): no push, no pop
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage holds a valid entry
- out_ready  in  1  downstream accepts this cycle
- out_data  out  WIDTH  payload to downstream
- occupancy  out  2  held entries: 0..2 (0..1 without skid)
- bp_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready & ~stall.
- State: main entry (out_valid, out_data), skid entry (skid_valid, skid_data, only when configured).
- Priority each edge: rst > flush > push/pop.
- rst: out_valid=0, skid_valid=0, out_data=RST_VAL, bp_cnt=0.
- flush (no rst): out_valid=0, skid_valid=0; data registers hold; a same-cycle push is dropped; bp_cnt still updates.
- With skid, transitions (no rst/flush):
  - main empty, push: main<=in_data.
  - main full, pop, skid empty, push: main<=in_data.
  - main full, pop, skid empty, no push: main empties.
  - main full, no pop, push: skid<=in_data (in_ready guarantees skid empty).
  - skid full, pop: main<=skid_data, skid empties. No push is possible (in_ready=0).
  - no push, no pop: hold.
- in_ready = ~skid_valid & ~stall & ~rst. Registered-state only, with no path from out_ready.
- stall: main and skid data/valid hold; out_valid stays visible, but no transfer occurs.
- bp_cnt increments (saturating at all-ones) every cycle with out_valid & (~out_ready | stall); cleared only by rst.
- occupancy = out_valid + skid_valid.
- FIFO order is preserved; no entry is duplicated or lost except by flush.

## Timing
- Latency: in_data accepted at edge N appears on out_data after edge N, i.e. in cycle N+1.
- Throughput: 1 entry/cycle sustained when out_ready=1 and stall=0.
- With skid: one cycle of downstream back-pressure costs no upstream bubble. in_ready drops the cycle after the skid fills and rises the cycle after the skid drains.
- rst asserted in cycle N: outputs at reset values from cycle N+1. in_ready=0 while rst=1, and is 1 in the first cycle after rst deasserts.
- stall and flush together: flush wins; stage is empty next cycle.

## Configuration
- PIPE_STAGE_REG_SKID_EN defined: skid entry present; occupancy 0..2; in_ready as above (registered-state only).
- Undefined: no skid registers; occupancy 0..1; in_ready = (~out_valid | out_ready) & ~stall & ~rst. This is a combinational path from out_ready. Push with pop replaces main; push without pop needs main empty.

## Test plan
- Reset: WIDTH=32, RST_VAL=32'h1C000000, rst 1 cycle -> out_valid=0, out_data=32'h1C000000, occupancy=0, bp_cnt=0, in_ready=1 next cycle.
- Streaming: push 1,2,3,4 back-to-back with out_ready=1 -> out_data 1,2,3,4 in cycles N+1..N+4, no bubbles, bp_cnt=0.
- Skid (SKID_EN): push A,B,C; out_ready=0 from cycle of B's arrival for 2 cycles -> occupancy 2, in_ready=0, C held upstream; release -> A,B,C delivered in order, none lost.
- Stall: main holds X, stall=1 for 3 cycles with out_ready=1 -> out_data=X held, no pop, in_ready=0, bp_cnt=3.
- Flush: occupancy 2, flush=1 with in_valid=1 (data D) -> next cycle out_valid=0, occupancy=0, D not captured.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> bp_cnt stops at 15.
